// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - age-ordered collapsing reservation station feeding one ALU
//
// Purpose: holds dispatched ALU ops until both source operands are ready, then
// issues the oldest ready entry. Snoops writeback tag buses for wakeup and
// squashes entries younger than a mispredicted branch.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   dispatch_valid/_struct    incoming packet {op, itype, src0, src1, dest, imm16, ROB}
//                             each src is {needed, ready, tag[5:0]}
//   dispatch_ready            registered count below capacity
//   wb_valid/wb_phys_reg_tag  writeback tag buses used for wakeup
//   issue_*                   chosen entry towards the ALU, valid/ready handshake
//   kill_valid/kill_ROB_index squash everything younger than kill_ROB_index
//   ROB_head_index            reference point for age comparison
module alu_reservation_station #(
    parameter int RS_DEPTH     = 4,
    parameter int NUM_WB_BUSES = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      dispatch_valid,
    input  logic [47:0]               dispatch_struct,
    output logic                      dispatch_ready,
    input  logic [NUM_WB_BUSES-1:0]   wb_valid,
    input  logic [NUM_WB_BUSES*6-1:0] wb_phys_reg_tag,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [3:0]                issue_op,
    output logic                      issue_itype,
    output logic [5:0]                issue_source_0_tag,
    output logic [5:0]                issue_source_1_tag,
    output logic [5:0]                issue_dest_phys_reg_tag,
    output logic [15:0]               issue_imm16,
    output logic [4:0]                issue_ROB_index,
    input  logic                      kill_valid,
    input  logic [4:0]                kill_ROB_index,
    input  logic [4:0]                ROB_head_index
);
    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    // Field order matches the dispatch packet bit layout, MSB first.
    typedef struct packed {
        logic [3:0]  op;
        logic        itype;
        logic        s0_needed;
        logic        s0_ready;
        logic [5:0]  s0_tag;
        logic        s1_needed;
        logic        s1_ready;
        logic [5:0]  s1_tag;
        logic [5:0]  dest;
        logic [15:0] imm16;
        logic [4:0]  rob;
    } entry_t;

    entry_t          entries_q [RS_DEPTH];
    entry_t          entries_d [RS_DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic [RS_DEPTH-1:0] rdy;
    logic [RS_DEPTH-1:0] killed;
    logic [IW-1:0]       sel_idx;
    logic                issue_fire;
    logic                dispatch_fire;
    logic [4:0]          kill_age;
    logic [4:0]          ent_age;
    int                  killed_cnt;
    int                  j;

    function automatic logic wb_hit(input logic [5:0] tag);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < NUM_WB_BUSES; b++) begin
            if (wb_valid[b] && (wb_phys_reg_tag[b*6 +: 6] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Ready bits pick up any matching writeback at the edge they are stored.
    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        r.s0_ready = e.s0_ready | (e.s0_needed & wb_hit(e.s0_tag));
        r.s1_ready = e.s1_ready | (e.s1_needed & wb_hit(e.s1_tag));
        return r;
    endfunction

    assign dispatch_ready = (count_q < CW'(RS_DEPTH));

    always_comb begin
        rdy        = '0;
        killed     = '0;
        sel_idx    = '0;
        killed_cnt = 0;
        kill_age   = kill_ROB_index - ROB_head_index;
        ent_age    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (i < int'(count_q)) begin
                rdy[i] = (!entries_q[i].s0_needed || entries_q[i].s0_ready) &&
                         (!entries_q[i].s1_needed || entries_q[i].s1_ready);
                ent_age = entries_q[i].rob - ROB_head_index;
                killed[i] = kill_valid && (ent_age > kill_age);
                if (killed[i]) killed_cnt = killed_cnt + 1;
            end
        end
        // Scan downwards so the lowest (oldest) ready index wins.
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) sel_idx = IW'(i);
        end
    end

    assign issue_valid = |rdy;

    // A handshake on an entry being killed this cycle is void; the ALU sees kill_valid too.
    assign issue_fire    = issue_valid && issue_ready && !killed[sel_idx];
    assign dispatch_fire = dispatch_valid && dispatch_ready && !kill_valid;

    always_comb begin
        entries_d = entries_q;
        j         = 0;
        // Compact survivors into slots 0.. preserving age order, waking as they move.
        for (int i = 0; i < RS_DEPTH; i++) begin
            if ((i < int'(count_q)) && !killed[i] && !(issue_fire && (IW'(i) == sel_idx))) begin
                entries_d[j[IW-1:0]] = wake(entries_q[i]);
                j = j + 1;
            end
        end
        // j equals count (or count-1 after an issue); dispatch_ready guarantees a free slot.
        if (dispatch_fire) begin
            entries_d[j[IW-1:0]] = wake(entry_t'(dispatch_struct));
        end
        count_d = CW'(j) + CW'(dispatch_fire);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= '0;
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
            assert (int'(count_q) - int'(issue_fire) - killed_cnt + int'(dispatch_fire) == int'(count_d));
            assert (int'(count_d) <= RS_DEPTH);
        end
    end

    always_comb begin
        issue_op                = '0;
        issue_itype             = '0;
        issue_source_0_tag      = '0;
        issue_source_1_tag      = '0;
        issue_dest_phys_reg_tag = '0;
        issue_imm16             = '0;
        issue_ROB_index         = '0;
        if (issue_valid) begin
            issue_op                = entries_q[sel_idx].op;
            issue_itype             = entries_q[sel_idx].itype;
            issue_source_0_tag      = entries_q[sel_idx].s0_tag;
            issue_source_1_tag      = entries_q[sel_idx].s1_tag;
            issue_dest_phys_reg_tag = entries_q[sel_idx].dest;
            issue_imm16             = entries_q[sel_idx].imm16;
            issue_ROB_index         = entries_q[sel_idx].rob;
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - scoreboard bench for alu_reservation_station
module tb_alu_reservation_station;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dispatch_valid = 1'b0;
    logic [47:0] dispatch_struct = '0;
    logic        dispatch_ready;
    logic [2:0]  wb_valid = '0;
    logic [17:0] wb_phys_reg_tag = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [3:0]  issue_op;
    logic        issue_itype;
    logic [5:0]  issue_source_0_tag;
    logic [5:0]  issue_source_1_tag;
    logic [5:0]  issue_dest_phys_reg_tag;
    logic [15:0] issue_imm16;
    logic [4:0]  issue_ROB_index;
    logic        kill_valid = 1'b0;
    logic [4:0]  kill_ROB_index = '0;
    logic [4:0]  ROB_head_index = '0;

    int checks = 0;
    int errors = 0;
    logic [43:0] exp_q[$];

    alu_reservation_station #(.RS_DEPTH(4), .NUM_WB_BUSES(3)) dut (
        .CLK(CLK), .RST(RST),
        .dispatch_valid(dispatch_valid), .dispatch_struct(dispatch_struct),
        .dispatch_ready(dispatch_ready),
        .wb_valid(wb_valid), .wb_phys_reg_tag(wb_phys_reg_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_itype(issue_itype),
        .issue_source_0_tag(issue_source_0_tag), .issue_source_1_tag(issue_source_1_tag),
        .issue_dest_phys_reg_tag(issue_dest_phys_reg_tag), .issue_imm16(issue_imm16),
        .issue_ROB_index(issue_ROB_index),
        .kill_valid(kill_valid), .kill_ROB_index(kill_ROB_index),
        .ROB_head_index(ROB_head_index)
    );

    always #5 CLK = ~CLK;

    // Packet layout: op4 itype1 {n,r,tag6} {n,r,tag6} dest6 imm16 rob5.
    function automatic logic [47:0] mk(input logic [3:0] op, input logic s0n, input logic s0r,
                                       input logic [5:0] s0t, input logic s1n, input logic s1r,
                                       input logic [5:0] s1t, input logic [5:0] dest,
                                       input logic [15:0] imm, input logic [4:0] rob);
        return {op, 1'b0, s0n, s0r, s0t, s1n, s1r, s1t, dest, imm, rob};
    endfunction

    function automatic logic [43:0] exp_of(input logic [47:0] p);
        return {p[47:44], p[43], p[40:35], p[32:27], p[26:21], p[20:5], p[4:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic dispatch(input logic [47:0] p);
        dispatch_valid  = 1'b1;
        dispatch_struct = p;
        tick();
        dispatch_valid  = 1'b0;
        dispatch_struct = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Monitor: every completed (non-killed) handshake pops one expected packet.
    always @(negedge CLK) begin
        if (!RST && issue_valid && issue_ready && !kill_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got rob %0d dest %0d expected none",
                         issue_ROB_index, issue_dest_phys_reg_tag);
            end else begin
                logic [43:0] e;
                logic [43:0] a;
                e = exp_q.pop_front();
                a = {issue_op, issue_itype, issue_source_0_tag, issue_source_1_tag,
                     issue_dest_phys_reg_tag, issue_imm16, issue_ROB_index};
                if (a !== e) begin
                    errors++;
                    $display("FAIL issue_pkt: got %0h expected %0h", a, e);
                end
            end
        end
    end

    initial begin
        logic [47:0] p;

        // Reset state
        do_reset();
        check("rst_issue_valid", issue_valid, 0);
        check("rst_dispatch_ready", dispatch_ready, 1);
        check("rst_issue_dest", issue_dest_phys_reg_tag, 0);
        check("rst_issue_rob", issue_ROB_index, 0);

        // Single ready ADD
        issue_ready = 1'b1;
        p = mk(4'h1, 1, 1, 6'd5, 1, 1, 6'd6, 6'd40, 16'h1234, 5'd3);
        exp_q.push_back(exp_of(p));
        dispatch(p);
        check("t1_issue_valid", issue_valid, 1);
        check("t1_dest", issue_dest_phys_reg_tag, 40);
        check("t1_rob", issue_ROB_index, 3);
        tick();
        check("t1_empty_valid", issue_valid, 0);
        check("t1_empty_ready", dispatch_ready, 1);

        // A waits on tag 10, younger B is ready and overtakes it
        p = mk(4'h2, 1, 0, 6'd10, 0, 0, 6'd0, 6'd41, 16'h0001, 5'd4);
        dispatch(p);
        check("t2_a_blocked", issue_valid, 0);
        exp_q.push_back(mk(4'h3, 0, 0, 6'd1, 0, 0, 6'd2, 6'd42, 16'h0002, 5'd5) == '0 ? '0 :
                        exp_of(mk(4'h3, 0, 0, 6'd1, 0, 0, 6'd2, 6'd42, 16'h0002, 5'd5)));
        exp_q.push_back(exp_of(p));
        dispatch(mk(4'h3, 0, 0, 6'd1, 0, 0, 6'd2, 6'd42, 16'h0002, 5'd5));
        wb_valid = 3'b001;
        wb_phys_reg_tag = {6'd0, 6'd0, 6'd10};
        check("t2_b_first", issue_dest_phys_reg_tag, 42);
        tick();
        wb_valid = '0;
        check("t2_a_after_wb", issue_valid, 1);
        check("t2_a_dest", issue_dest_phys_reg_tag, 41);
        tick();
        check("t2_drained", issue_valid, 0);

        // Same-cycle writeback bypass on dispatch (bus 2)
        p = mk(4'h4, 1, 0, 6'd12, 0, 0, 6'd0, 6'd43, 16'h00ff, 5'd6);
        exp_q.push_back(exp_of(p));
        wb_valid = 3'b100;
        wb_phys_reg_tag = {6'd12, 6'd0, 6'd0};
        dispatch(p);
        wb_valid = '0;
        check("t3_bypass_valid", issue_valid, 1);
        check("t3_bypass_dest", issue_dest_phys_reg_tag, 43);
        tick();
        check("t3_drained", issue_valid, 0);

        // Fill, overflow attempt, wake out of order, drain in ROB order
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = mk(4'h5, 1, 0, 6'(20 + i), 0, 0, 6'd0, 6'(50 + i), 16'(i), 5'(7 + i));
            exp_q.push_back(exp_of(p));
            dispatch(p);
        end
        check("t4_full_ready", dispatch_ready, 0);
        check("t4_full_valid", issue_valid, 0);
        dispatch(mk(4'h6, 0, 0, 6'd0, 0, 0, 6'd0, 6'd59, 16'h0, 5'd11));
        check("t4_overflow_ignored_ready", dispatch_ready, 0);
        check("t4_overflow_ignored_valid", issue_valid, 0);
        wb_valid = 3'b111;
        wb_phys_reg_tag = {6'd21, 6'd22, 6'd23};
        tick();
        check("t4_partial_rob", issue_ROB_index, 8);
        wb_valid = 3'b001;
        wb_phys_reg_tag = {6'd0, 6'd0, 6'd20};
        tick();
        wb_valid = '0;
        check("t4_oldest_rob", issue_ROB_index, 7);
        issue_ready = 1'b1;
        check("t4_no_credit", dispatch_ready, 0);
        tick();
        check("t4_ready_after_issue", dispatch_ready, 1);
        tick();
        tick();
        tick();
        check("t4_drained", issue_valid, 0);

        // Kill with ROB wrap-around
        issue_ready = 1'b0;
        ROB_head_index = 5'd30;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] r;
            r = 5'(30 + i);
            p = mk(4'h7, 0, 0, 6'd0, 0, 0, 6'd0, 6'(60 + i), 16'h0, r);
            if (i < 2) exp_q.push_back(exp_of(p));
            dispatch(p);
        end
        kill_valid = 1'b1;
        kill_ROB_index = 5'd31;
        dispatch(mk(4'h8, 0, 0, 6'd0, 0, 0, 6'd0, 6'd7, 16'h0, 5'd2));
        kill_valid = 1'b0;
        check("t5_count2_ready", dispatch_ready, 1);
        check("t5_head_rob", issue_ROB_index, 30);
        kill_valid = 1'b1;
        dispatch(mk(4'h8, 0, 0, 6'd0, 0, 0, 6'd0, 6'd8, 16'h0, 5'd2));
        kill_valid = 1'b0;
        issue_ready = 1'b1;
        tick();
        check("t5_second_rob", issue_ROB_index, 31);
        tick();
        check("t5_drained", issue_valid, 0);
        tick();
        ROB_head_index = '0;

        // Reset with three held entries
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dispatch(mk(4'h9, 0, 0, 6'd0, 0, 0, 6'd0, 6'(1 + i), 16'h0, 5'(12 + i)));
        end
        check("t6_pre_valid", issue_valid, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t6_rst_valid", issue_valid, 0);
        check("t6_rst_ready", dispatch_ready, 1);
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t6_no_stale", issue_valid, 0);

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Consumer end of the dispatch -> ALU issue interface: accepts ALU_RS_input_struct_t packets from dispatch, holds them until both source phys regs are ready, then issues the oldest ready entry to one ALU pipeline.
- Snoops the writeback tag buses for wakeup.
- Squashes entries younger than a mispredicted branch on kill.
- One instance per ALU (ALU_0, ALU_1).

Parameters:
- RS_DEPTH, 4, number of entries (age-ordered, collapsing)
- NUM_WB_BUSES, 3, writeback tag buses snooped (ALU_0, ALU_1, LQ)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- dispatch_valid  in  1  dispatch packet present
- dispatch_struct  in  48  ALU_RS_input_struct_t {op, itype, source_0, source_1, dest_phys_reg_tag, imm16, ROB_index}
- dispatch_ready  out  1  RS can accept a packet this cycle
- wb_valid  in  NUM_WB_BUSES  per-bus writeback valid
- wb_phys_reg_tag  in  NUM_WB_BUSES*6  per-bus written phys reg tag
- issue_valid  out  1  issue packet present
- issue_ready  in  1  ALU accepts packet
- issue_op  out  4  ALU_op_t
- issue_itype  out  1  immediate form
- issue_source_0_tag  out  6  phys reg tag for operand read
- issue_source_1_tag  out  6  phys reg tag for operand read
- issue_dest_phys_reg_tag  out  6  destination phys reg
- issue_imm16  out  16  immediate
- issue_ROB_index  out  5  ROB index
- kill_valid  in  1  squash younger than kill_ROB_index
- kill_ROB_index  in  5  ROB index of mispredicted instr (survives)
- ROB_head_index  in  5  current ROB head, for age compare

Behaviour:
- Reset (sync, RST=1 at posedge):
  - all entries invalid, count=0.
  - Outputs: issue_valid=0, dispatch_ready=1, all other issue_* outputs 0.
  - Reset mid-operation discards all entries with no issue.
- Storage: entries 0..RS_DEPTH-1, entry 0 oldest.
  - Valid entries are contiguous from 0.
  - count is registered, 0..RS_DEPTH.
- Source ready: a source is ready if its needed=0 or its ready=1.
- Select:
  - issue_valid = OR over valid entries with both sources ready.
  - Chosen entry = lowest index among those. All issue_* outputs are driven combinationally from the chosen entry's registered state.
- Issue handshake:
  - Fires when issue_valid & issue_ready.
  - The chosen entry is removed at the clock edge; younger entries shift down one slot.
  - issue_valid is not gated by issue_ready.
  - Outputs hold stable while issue_valid=1 & issue_ready=0 unless an older entry becomes ready.
- Wakeup:
  - For each valid entry source with needed=1, ready=0: if any wb_valid[i] with wb_phys_reg_tag[i]==phys_reg_tag, set ready at the edge.
  - The entry becomes issuable the following cycle (wb edge N, issue_valid at N+1).
  - Wakeup applies to entries as they shift.
- Dispatch:
  - dispatch_ready = (count < RS_DEPTH), from registered count.
  - Does not credit a same-cycle issue (conservative).
  - Accepted when dispatch_valid & dispatch_ready & !kill_valid.
  - Written at slot count, or count-1 if an issue fires the same cycle.
  - Same-cycle wb tags matching the incoming sources are applied on write (no lost wakeup).
  - Earliest issue is the cycle after dispatch.
  - dispatch_valid while dispatch_ready=0 is ignored; the sender holds the packet.
- Kill:
  - age(x) = (x - ROB_head_index) mod 32.
  - On kill_valid, every entry with age(ROB_index) > age(kill_ROB_index) is invalidated.
  - Survivors compact to slots 0.. preserving order; count updates accordingly.
  - Dispatch in the kill cycle is dropped.
  - A same-cycle issue handshake still completes if the issued entry is not killed. A killed chosen entry's handshake is ignored: the ALU must drop it, since kill_valid is visible to it.
- Simultaneous issue + dispatch with count=RS_DEPTH: dispatch_ready=0, so only the issue occurs; next cycle count=RS_DEPTH-1 and dispatch_ready=1.
- Count arithmetic is 3-bit unsigned: count_next = count - issue_fire - killed_count + dispatch_fire. Never below 0 or above RS_DEPTH; a violation is an assertion failure.

Test Plan:
- Reset, then dispatch ADD {src0 tag 5 ready, src1 tag 6 ready, dest 40, ROB 3} with issue_ready=1 -> issue_valid=1 next cycle, issue_dest_phys_reg_tag=40, issue_ROB_index=3; count back to 0.
- Dispatch entry A {src0 tag 10 not ready}, then B {all ready}; wb tag 10 in a later cycle -> B issues first; A issues the cycle after the wb edge (not in the wb cycle).
- Dispatch with a src tag 12 not ready in the same cycle wb_valid[2]=1, tag 12 -> entry issues next cycle (same-cycle bypass).
- Fill 4 not-ready entries -> dispatch_ready=0, a fifth dispatch_valid is ignored. Wake all -> issue order is ROB order. dispatch_ready returns 1 the cycle after the first issue.
- ROB_head=30, entries ROB {30, 31, 0, 1}; kill_valid with kill_ROB_index=31 -> entries 0 and 1 removed, count=2, entries 30 and 31 remain in order; a same-cycle dispatch is dropped.
- Assert RST with 3 valid ready entries and issue_ready=0 -> next cycle issue_valid=0, dispatch_ready=1, and no later issue of old entries.
